// File: rtl/ahb_ram_slave.sv
// AHB (AMBA 2.0) slave in front of a word-organised on-chip RAM.
// Supports byte/halfword/word transfers with big- or little-endian lane mapping,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_ram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    logic [31:0]   mem [MEM_WORDS];

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] lat_idx;
    logic [1:0]    lat_off;
    logic [1:0]    lat_size;
    logic          lat_write;
    logic          ready_q;
    logic [1:0]    resp_q;
    logic [31:0]   rdata_q;

    logic          accept;
    logic          illegal;
    logic          wr_en;
    logic [AW:0]   range_idx;
    logic [AW-1:0] ap_idx;
    logic [3:0]    byte_en;
    logic [3:0]    lane_en;
    logic [31:0]   lane_mask;
    logic [31:0]   wr_word;
    logic [31:0]   ap_word;
    logic          unused_ok;

    assign accept    = HSEL & HREADY & HTRANS[1];
    // One bit above the used index so an address one RAM-size past the end is flagged
    // instead of silently aliasing onto word 0.
    assign range_idx = HADDR[AW+2:2];
    assign ap_idx    = HADDR[AW+1:2];
    assign wr_en     = (state == S_DATA) && lat_write;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], HADDR[31:AW+3]};

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;
    assign HRDATA    = rdata_q;

    // Classify the address phase on the bus as legal or illegal.
    always_comb begin
        illegal = 1'b0;
        case (HSIZE)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = HADDR[0];
            3'b010:  illegal = (HADDR[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
        if (32'(range_idx) >= 32'(MEM_WORDS))
            illegal = 1'b1;
    end

    // Byte enables, lane mask, merged write word and read-after-write bypass.
    always_comb begin
        case (lat_size)
            2'b00:   byte_en = 4'b0001 << lat_off;
            2'b01:   byte_en = lat_off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
        lane_en   = (BIG_ENDIAN != 0) ? {byte_en[0], byte_en[1], byte_en[2], byte_en[3]}
                                      : byte_en;
        lane_mask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
        wr_word   = (mem[lat_idx] & ~lane_mask) | (HWDATA & lane_mask);
        // With no wait states the read is captured at the same edge the pending write
        // commits, so forward the merged word instead of the stale RAM contents.
        ap_word   = (wr_en && (ap_idx == lat_idx)) ? wr_word : mem[ap_idx];
    end

    // RAM write port: commit at the edge that ends a write data phase.
    always_ff @(posedge HCLK) begin
        if (wr_en)
            mem[lat_idx] <= wr_word;
    end

    // Transfer FSM with registered HREADYOUT/HRESP/HRDATA.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            lat_idx   <= '0;
            lat_off   <= '0;
            lat_size  <= '0;
            lat_write <= 1'b0;
            ready_q   <= 1'b1;
            resp_q    <= 2'b00;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= S_DATA;
                        ready_q <= 1'b1;
                        if (!lat_write)
                            rdata_q <= mem[lat_idx];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state   <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 2'b01;
                end
                default: begin
                    // IDLE, DATA and ERR2 are the ready cycles that may take an address phase.
                    if (accept) begin
                        lat_idx  <= ap_idx;
                        lat_off  <= HADDR[1:0];
                        lat_size <= HSIZE[1:0];
                        if (illegal) begin
                            state     <= S_ERR1;
                            ready_q   <= 1'b0;
                            resp_q    <= 2'b01;
                            lat_write <= 1'b0;
                        end else begin
                            lat_write <= HWRITE;
                            resp_q    <= 2'b00;
                            if (WAIT_STATES > 0) begin
                                state    <= S_WAIT;
                                ready_q  <= 1'b0;
                                wait_cnt <= 4'(WAIT_STATES - 1);
                            end else begin
                                state   <= S_DATA;
                                ready_q <= 1'b1;
                                if (!HWRITE)
                                    rdata_q <= ap_word;
                            end
                        end
                    end else begin
                        state     <= S_IDLE;
                        ready_q   <= 1'b1;
                        resp_q    <= 2'b00;
                        lat_write <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: two instances (0 and 3 wait states) share one master;
// expected responses are queued as address phases are issued and checked on completion.
module tb_ahb_ram_slave;
    localparam int MEM_WORDS = 1024;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic        sel_on = 1'b0;
    logic        use3 = 1'b0;
    logic        other_busy = 1'b0;
    logic        hsel0, hsel3;
    logic        rdy0, rdy3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rd0, rd3;
    logic        cur_rdy;
    logic [1:0]  cur_resp;
    logic [31:0] cur_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    xfer_t       txq[$];
    exp_t        expq[$];
    logic [31:0] model [2][MEM_WORDS];

    always #5 HCLK = ~HCLK;

    assign hsel0     = sel_on & ~use3;
    assign hsel3     = sel_on & use3;
    assign cur_rdy   = use3 ? rdy3 : rdy0;
    assign cur_resp  = use3 ? resp3 : resp0;
    assign cur_rdata = use3 ? rd3 : rd0;

    ahb_ram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(0), .BIG_ENDIAN(1)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HWDATA(hwdata),
        .HREADY(rdy0 & ~other_busy), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

    ahb_ram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(3), .BIG_ENDIAN(1)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HWDATA(hwdata),
        .HREADY(rdy3 & ~other_busy), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rd3));

    function automatic xfer_t mk(input logic [31:0] a, input logic wr,
                                 input logic [2:0] sz, input logic [31:0] d);
        xfer_t t;
        t.addr = a; t.wr = wr; t.size = sz; t.wdata = d;
        return t;
    endfunction

    function automatic bit is_illegal(input xfer_t t);
        if (t.size > 3'd2) return 1'b1;
        if (t.size == 3'd1 && t.addr[0]) return 1'b1;
        if (t.size == 3'd2 && t.addr[1:0] != 2'b00) return 1'b1;
        if (t.addr[31:2] >= MEM_WORDS) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: big-endian, byte address a sits in bits [8*(3-a)+7 : 8*(3-a)].
    function automatic void push_expect(input xfer_t t);
        exp_t        e;
        int          w, a, pos;
        logic [31:0] word;
        e.err   = is_illegal(t);
        e.rd    = !t.wr;
        e.waits = use3 ? 3 : 0;
        e.data  = 'x;
        w = int'(t.addr[14:2]);
        if (!e.err) begin
            if (t.wr) begin
                word = model[use3][w];
                for (int i = 0; i < (1 << t.size); i++) begin
                    a = int'(t.addr[1:0]) + i;
                    pos = 8 * (3 - a);
                    word[pos +: 8] = t.wdata[pos +: 8];
                end
                model[use3][w] = word;
            end else begin
                e.data = model[use3][w];
            end
        end
        expq.push_back(e);
    endfunction

    task automatic drive_ap(input xfer_t t);
        haddr = t.addr; hwrite = t.wr; hsize = t.size; htrans = 2'b10; sel_on = 1'b1;
        push_expect(t);
    endtask

    task automatic drive_idle();
        htrans = 2'b00; sel_on = 1'b0; hwrite = 1'b0; haddr = '0;
    endtask

    // Pipelined master: issues txq back to back, checks each data phase against expq.
    task automatic run_seq(input string name);
        xfer_t       ap, dp;
        bit          ap_act, dp_act, dp_bad, r;
        int          waits, errc, cyc, beat;
        logic [1:0]  s;
        logic [31:0] d;
        exp_t        e;
        ap_act = 0; dp_act = 0; dp_bad = 0; waits = 0; errc = 0; cyc = 0; beat = 0;
        if (txq.size() > 0) begin
            ap = txq.pop_front(); drive_ap(ap); ap_act = 1;
        end
        while ((ap_act || dp_act || txq.size() > 0) && cyc < 400) begin
            @(negedge HCLK);
            cyc++;
            r = (cur_rdy === 1'b1); s = cur_resp; d = cur_rdata;
            if (dp_act) begin
                if (s !== 2'b00) errc++;
                if (!r) waits++;
                else begin
                    e = expq.pop_front();
                    tests_run++;
                    if (e.err) begin
                        if (s !== 2'b01 || waits !== 1 || errc !== 2) begin
                            tests_failed++;
                            $display("FAIL %s beat %0d err: resp=%b lowcycles=%0d errcycles=%0d, required resp=01 lowcycles=1 errcycles=2",
                                     name, beat, s, waits, errc);
                        end
                    end else begin
                        if (s !== 2'b00 || waits !== e.waits || errc !== 0) begin
                            tests_failed++;
                            $display("FAIL %s beat %0d okay: resp=%b lowcycles=%0d errcycles=%0d, required resp=00 lowcycles=%0d errcycles=0",
                                     name, beat, s, waits, errc, e.waits);
                        end
                        if (e.rd) begin
                            tests_run++;
                            if (d !== e.data) begin
                                tests_failed++;
                                $display("FAIL %s beat %0d rdata: got %h, required %h", name, beat, d, e.data);
                            end
                        end
                    end
                    beat++;
                end
            end
            @(posedge HCLK); #1;
            if (r) begin
                dp_act = ap_act;
                if (ap_act) dp = ap;
                dp_bad = ap_act && is_illegal(ap);
                waits = 0; errc = 0;
                hwdata = (dp_act && dp.wr) ? dp.wdata : $urandom();
                if (txq.size() > 0 && !dp_bad) begin
                    ap = txq.pop_front(); drive_ap(ap); ap_act = 1;
                end else begin
                    drive_idle(); ap_act = 0;
                end
            end else if (dp_bad && s === 2'b01 && !ap_act && txq.size() > 0) begin
                // Present the next address during ERR2 so it is taken at the end of ERR2.
                ap = txq.pop_front(); drive_ap(ap); ap_act = 1;
            end
        end
        if (ap_act || dp_act || txq.size() > 0) begin
            tests_run++; tests_failed++;
            $display("FAIL %s timeout: transfers still pending after %0d cycles, required completion", name, cyc);
            txq.delete(); expq.delete(); drive_idle();
        end
    endtask

    task automatic test_reset();
        drive_idle(); other_busy = 0; use3 = 0; hwdata = '0;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        tests_run += 3;
        if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b/%b, required 1/1", rdy0, rdy3); end
        if (resp0 !== 2'b00 || resp3 !== 2'b00) begin tests_failed++; $display("FAIL reset_resp: got %b/%b, required 00/00", resp0, resp3); end
        if (rd0 !== 32'h0 || rd3 !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h/%h, required 0/0", rd0, rd3); end
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
    endtask

    task automatic test_word_rw();
        use3 = 0;
        txq.push_back(mk(32'h10, 1, 3'd2, 32'hDEADBEEF)); run_seq("word_wr");
        txq.push_back(mk(32'h10, 0, 3'd2, 32'h0));        run_seq("word_rd");
    endtask

    task automatic test_byte_half();
        use3 = 0;
        txq.push_back(mk(32'h20, 1, 3'd0, 32'h11A5A5A5));
        txq.push_back(mk(32'h21, 1, 3'd0, 32'hA522A5A5));
        txq.push_back(mk(32'h22, 1, 3'd0, 32'hA5A533A5));
        txq.push_back(mk(32'h23, 1, 3'd0, 32'hA5A5A544));
        run_seq("byte_wr");
        txq.push_back(mk(32'h20, 0, 3'd2, 32'h0)); run_seq("byte_rd");
        txq.push_back(mk(32'h22, 1, 3'd1, 32'h5A5AAABB));
        txq.push_back(mk(32'h20, 0, 3'd2, 32'h0));
        run_seq("half_wr_rd");
    endtask

    task automatic test_raw(input logic sel3);
        use3 = sel3;
        txq.push_back(mk(32'h30, 1, 3'd2, 32'hCAFEF00D));
        txq.push_back(mk(32'h30, 0, 3'd2, 32'h0));
        txq.push_back(mk(32'h31, 1, 3'd0, 32'h00770000));
        txq.push_back(mk(32'h30, 0, 3'd2, 32'h0));
        run_seq(sel3 ? "raw_ws3" : "raw_ws0");
    endtask

    task automatic test_wait_states();
        use3 = 1;
        txq.push_back(mk(32'h60, 1, 3'd2, 32'h0BADF00D)); run_seq("ws3_wr");
        txq.push_back(mk(32'h60, 0, 3'd2, 32'h0));        run_seq("ws3_rd");
    endtask

    task automatic test_errors(input logic sel3);
        use3 = sel3;
        txq.push_back(mk(32'h00, 1, 3'd2, 32'h01020304));
        txq.push_back(mk(32'h04, 1, 3'd2, 32'h05060708));
        run_seq("err_pre");
        txq.push_back(mk(32'h02, 1, 3'd2, 32'hFFFFFFFF));   run_seq("err_misaligned_word");
        txq.push_back(mk(32'h04, 1, 3'd3, 32'hFFFFFFFF));   run_seq("err_size3");
        txq.push_back(mk(32'h1000, 1, 3'd2, 32'hFFFFFFFF)); run_seq("err_index_max");
        txq.push_back(mk(32'h01, 1, 3'd1, 32'hFFFFFFFF));   run_seq("err_odd_half");
        txq.push_back(mk(32'h04, 0, 3'd3, 32'h0));
        txq.push_back(mk(32'h00, 0, 3'd2, 32'h0));
        txq.push_back(mk(32'h04, 0, 3'd2, 32'h0));
        run_seq("err_then_read");
    endtask

    task automatic test_back_to_back();
        use3 = 0;
        for (int i = 0; i < 6; i++)
            txq.push_back(mk(32'h100 + 32'(4 * i), 1, 3'd2, $urandom()));
        for (int i = 0; i < 6; i++)
            txq.push_back(mk(32'h100 + 32'(4 * i), 0, 3'd2, 32'h0));
        run_seq("back_to_back");
    endtask

    task automatic test_hready_low();
        use3 = 1;
        txq.push_back(mk(32'h50, 1, 3'd2, 32'h2468ACE0)); run_seq("hrdy_pre");
        other_busy = 1;
        haddr = 32'h50; hwrite = 1; hsize = 3'd2; htrans = 2'b10; sel_on = 1; hwdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            tests_run++;
            if (rdy3 !== 1'b1 || resp3 !== 2'b00) begin
                tests_failed++;
                $display("FAIL hready_low cycle %0d: ready=%b resp=%b, required ready=1 resp=00", i, rdy3, resp3);
            end
            @(posedge HCLK); #1;
        end
        drive_idle(); other_busy = 0;
        @(negedge HCLK);
        tests_run++;
        if (rdy3 !== 1'b1) begin tests_failed++; $display("FAIL hready_low_after: ready=%b, required 1", rdy3); end
        @(posedge HCLK); #1;
        txq.push_back(mk(32'h50, 0, 3'd2, 32'h0)); run_seq("hrdy_read");
    endtask

    task automatic test_reset_mid_wait();
        use3 = 1;
        txq.push_back(mk(32'h40, 1, 3'd2, 32'h13579BDF));
        txq.push_back(mk(32'h40, 0, 3'd2, 32'h0));
        run_seq("rst_pre");
        haddr = 32'h40; hwrite = 1; hsize = 3'd2; htrans = 2'b10; sel_on = 1;
        @(posedge HCLK); #1;
        drive_idle(); hwdata = 32'hFFFFFFFF;
        @(negedge HCLK);
        tests_run++;
        if (rdy3 !== 1'b0) begin tests_failed++; $display("FAIL rst_in_wait: ready=%b, required 0", rdy3); end
        @(posedge HCLK); #2;
        HRESETn = 1'b0;
        #1;
        tests_run++;
        if (rdy3 !== 1'b1 || resp3 !== 2'b00 || rd3 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_outputs: ready=%b resp=%b rdata=%h, required 1 00 00000000", rdy3, resp3, rd3);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        txq.push_back(mk(32'h40, 0, 3'd2, 32'h0)); run_seq("rst_read");
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_raw(1'b0);
        test_raw(1'b1);
        test_wait_states();
        test_errors(1'b0);
        test_errors(1'b1);
        test_back_to_back();
        test_hready_low();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
